// File: rtl/seg7_pkg.sv
// ------------------------------------------------------------------
// seg7_pkg: shared 7-segment pattern constants (bits a..g, 0 = on)
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package seg7_pkg;

  localparam logic [6:0] SEG7_0     = 7'b0000001;
  localparam logic [6:0] SEG7_1     = 7'b1001111;
  localparam logic [6:0] SEG7_2     = 7'b0010010;
  localparam logic [6:0] SEG7_3     = 7'b0000110;
  localparam logic [6:0] SEG7_4     = 7'b1001100;
  localparam logic [6:0] SEG7_5     = 7'b0100100;
  localparam logic [6:0] SEG7_6     = 7'b0100000;
  localparam logic [6:0] SEG7_7     = 7'b0001111;
  localparam logic [6:0] SEG7_8     = 7'b0000000;
  localparam logic [6:0] SEG7_9     = 7'b0000100;
  localparam logic [6:0] SEG7_BLANK = 7'b1111111;

  localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

`default_nettype wire

// File: rtl/seg7_pattern_decode.sv
// ------------------------------------------------------------------
// seg7_pattern_decode: 7-bit active-low pattern -> {value, illegal flag}
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] i_pattern,
  output logic [3:0] o_value,
  output logic       o_err
);

  always_comb begin
    o_value = BLANK_CODE;
    o_err   = 1'b0;
    case (i_pattern)
      SEG7_0:     o_value = 4'd0;
      SEG7_1:     o_value = 4'd1;
      SEG7_2:     o_value = 4'd2;
      SEG7_3:     o_value = 4'd3;
      SEG7_4:     o_value = 4'd4;
      SEG7_5:     o_value = 4'd5;
      SEG7_6:     o_value = 4'd6;
      SEG7_7:     o_value = 4'd7;
      SEG7_8:     o_value = 4'd8;
      SEG7_9:     o_value = 4'd9;
      SEG7_BLANK: o_value = BLANK_CODE;
      default:    o_err   = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/seg7_scan_reader.sv
// ------------------------------------------------------------------
// seg7_scan_reader: recovers debounced digit values from scanned 7-seg lines
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SETTLE   = 2,
  parameter int STABLE_N = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [7:0]          SEG,
  input  logic [NDIG-1:0]     AN,
  output logic [4*NDIG-1:0]   DIGITS,
  output logic [NDIG-1:0]     DP,
  output logic [NDIG-1:0]     DIG_ERR,
  output logic                UPDATE,
  output logic                SCAN_ERR
);

  // Activation counter saturates one past SETTLE so a long activation samples once.
  localparam int c_CW = $clog2(SETTLE + 2);
  localparam int c_MW = $clog2(STABLE_N + 1);
  localparam int c_IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [c_CW-1:0] c_CNT_MAX = c_CW'(SETTLE + 1);
  localparam logic [c_CW-1:0] c_SETTLE  = c_CW'(SETTLE);
  localparam logic [c_MW-1:0] c_STABLE  = c_MW'(STABLE_N);

  logic [7:0]      r_seg;
  logic [NDIG-1:0] r_an;
  logic [NDIG-1:0] r_an_d;
  logic [c_CW-1:0] r_cnt;
  logic            r_multi_d;
  logic            r_update;
  logic            r_scan_err;

  logic [NDIG-1:0] w_low;
  logic            w_onehot;
  logic            w_multi;
  logic [c_IW-1:0] w_idx;
  logic [c_CW-1:0] w_cnt;
  logic            w_sample;
  logic [7:0]      w_key;
  logic [3:0]      w_val;
  logic            w_err;
  logic [NDIG-1:0] w_upd;

  assign w_low    = ~r_an;
  assign w_onehot = (w_low != '0) && ((w_low & (w_low - NDIG'(1))) == '0);
  assign w_multi  = (w_low != '0) && !w_onehot;
  assign w_key    = {r_seg[7:1], ~r_seg[0]};

  always_comb begin
    w_idx = '0;
    for (int k = 0; k < NDIG; k++) begin
      if (w_low[k]) w_idx = c_IW'(k);
    end
  end

  always_comb begin
    w_cnt = '0;
    if (w_onehot) begin
      if (r_an != r_an_d)        w_cnt = c_CW'(1);
      else if (r_cnt == c_CNT_MAX) w_cnt = r_cnt;
      else                       w_cnt = r_cnt + c_CW'(1);
    end
  end

  assign w_sample = w_onehot && (w_cnt == c_SETTLE);

  seg7_pattern_decode u_decode (
    .i_pattern (r_seg[7:1]),
    .o_value   (w_val),
    .o_err     (w_err)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_seg      <= '1;
      r_an       <= '1;
      r_an_d     <= '1;
      r_cnt      <= '0;
      r_multi_d  <= 1'b0;
      r_update   <= 1'b0;
      r_scan_err <= 1'b0;
    end else begin
      r_seg      <= SEG;
      r_an       <= AN;
      r_an_d     <= r_an;
      r_cnt      <= w_cnt;
      r_multi_d  <= w_multi;
      r_update   <= |w_upd;
      r_scan_err <= w_multi && !r_multi_d;
    end
  end

  generate
    for (genvar k = 0; k < NDIG; k++) begin : g_digit
      logic [7:0]      r_cand;
      logic [c_MW-1:0] r_match;
      logic [3:0]      r_val;
      logic            r_dp;
      logic            r_err;
      logic            w_hit;
      logic            w_same;
      logic [c_MW-1:0] w_next;
      logic            w_commit;

      assign w_hit  = w_sample && (w_idx == c_IW'(k));
      assign w_same = (w_key == r_cand);
      assign w_next = !w_same              ? c_MW'(1) :
                      (r_match == c_STABLE) ? r_match   : r_match + c_MW'(1);
      // A fresh candidate that reaches STABLE_N immediately still commits.
      assign w_commit = w_hit && (w_next == c_STABLE) &&
                        !(w_same && (r_match == c_STABLE));
      assign w_upd[k] = w_commit && ({w_val, w_key[0], w_err} != {r_val, r_dp, r_err});

      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
          r_cand  <= '0;
          r_match <= '0;
          r_val   <= BLANK_CODE;
          r_dp    <= 1'b0;
          r_err   <= 1'b0;
        end else begin
          if (w_hit) begin
            r_cand  <= w_key;
            r_match <= w_next;
          end
          if (w_commit) begin
            r_val <= w_val;
            r_dp  <= w_key[0];
            r_err <= w_err;
          end
        end
      end

      assign DIGITS[4*k +: 4] = r_val;
      assign DP[k]            = r_dp;
      assign DIG_ERR[k]       = r_err;
    end
  endgenerate

  assign UPDATE   = r_update;
  assign SCAN_ERR = r_scan_err;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_reader.sv
// ------------------------------------------------------------------
// tb_seg7_scan_reader: directed + random scan traffic against a streak model
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_seg7_scan_reader;

  localparam int NDIG     = 4;
  localparam int SETTLE   = 2;
  localparam int STABLE_N = 2;

  logic        CLK   = 1'b0;
  logic        RST_N = 1'b0;
  logic [7:0]  SEG   = 8'hFF;
  logic [3:0]  AN    = 4'hF;
  logic [15:0] DIGITS;
  logic [3:0]  DP;
  logic [3:0]  DIG_ERR;
  logic        UPDATE;
  logic        SCAN_ERR;

  seg7_scan_reader #(.NDIG(NDIG), .SETTLE(SETTLE), .STABLE_N(STABLE_N)) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .SEG      (SEG),
    .AN       (AN),
    .DIGITS   (DIGITS),
    .DP       (DP),
    .DIG_ERR  (DIG_ERR),
    .UPDATE   (UPDATE),
    .SCAN_ERR (SCAN_ERR)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int upd_seen = 0;
  int serr_seen = 0;
  bit saw5 = 1'b0;

  logic [6:0] pat_tab [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};

  typedef struct {
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  err;
    logic        upd;
    logic        serr;
  } exp_t;

  exp_t exp_q[$];

  // Model: committed outputs plus run-length history of AN and per-digit samples.
  logic [3:0] m_val    [4];
  logic       m_dp     [4];
  logic       m_err    [4];
  logic [7:0] m_last   [4];
  int         m_streak [4];
  logic [3:0] m_prev_an;
  bit         m_prev_valid;
  bit         m_prev_multi;
  int         m_run;

  function automatic exp_t snap(input logic upd, input logic serr);
    exp_t e;
    for (int k = 0; k < 4; k++) begin
      e.digits[4*k +: 4] = m_val[k];
      e.dp[k]            = m_dp[k];
      e.err[k]           = m_err[k];
    end
    e.upd  = upd;
    e.serr = serr;
    return e;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_val[k] = 4'hF; m_dp[k] = 1'b0; m_err[k] = 1'b0;
      m_last[k] = 8'h00; m_streak[k] = 0;
    end
    m_prev_an = 4'hF; m_prev_valid = 1'b0; m_prev_multi = 1'b0; m_run = 0;
  endtask

  task automatic decode(input logic [6:0] p, output logic [3:0] v, output logic e);
    v = 4'hF;
    e = (p != 7'h7F);
    for (int i = 0; i < 10; i++) begin
      if (pat_tab[i] == p) begin
        v = 4'(i);
        e = 1'b0;
      end
    end
  endtask

  // Result of the vector captured at edge n appears after edge n+1.
  task automatic model_cycle(input logic [3:0] an, input logic [7:0] seg);
    int nlow;
    int k;
    logic upd;
    logic serr;
    logic [7:0] key;
    logic [3:0] v;
    logic e;
    nlow = $countones(~an);
    upd  = 1'b0;
    k    = 0;
    if (nlow == 1) begin
      for (int i = 0; i < 4; i++) if (!an[i]) k = i;
      if (m_prev_valid && an == m_prev_an) m_run++;
      else m_run = 1;
      if (m_run == SETTLE) begin
        key = {seg[7:1], ~seg[0]};
        if (m_streak[k] > 0 && key == m_last[k]) m_streak[k]++;
        else begin
          m_last[k]   = key;
          m_streak[k] = 1;
        end
        if (m_streak[k] == STABLE_N) begin
          decode(seg[7:1], v, e);
          upd = (v != m_val[k]) || (key[0] != m_dp[k]) || (e != m_err[k]);
          m_val[k] = v; m_dp[k] = key[0]; m_err[k] = e;
        end
      end
    end else begin
      m_run = 0;
    end
    serr = (nlow >= 2) && !m_prev_multi;
    m_prev_multi = (nlow >= 2);
    m_prev_an    = an;
    m_prev_valid = 1'b1;
    exp_q.push_back(snap(upd, serr));
  endtask

  task automatic step(input logic [3:0] an, input logic [7:0] seg);
    @(negedge CLK);
    AN  = an;
    SEG = seg;
    model_cycle(an, seg);
  endtask

  task automatic idle(input int n);
    repeat (n) step(4'hF, 8'hFF);
  endtask

  task automatic activate(input int k, input logic [7:0] seg, input int len);
    repeat (len) step(~(4'b0001 << k), seg);
  endtask

  task automatic apply_reset(input int n);
    @(negedge CLK);
    RST_N = 1'b0;
    AN    = 4'hF;
    SEG   = 8'hFF;
    model_clear();
    exp_q.delete();
    exp_q.push_back(snap(1'b0, 1'b0));
    repeat (n) begin
      @(negedge CLK);
      exp_q.push_back(snap(1'b0, 1'b0));
    end
    @(negedge CLK);
    RST_N = 1'b1;
    model_cycle(AN, SEG);
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rand_seg();
    logic [7:0] s;
    int v;
    if ($urandom_range(0, 3) == 0) begin
      s = 8'($urandom);
    end else begin
      v = $urandom_range(0, 10);
      s[7:1] = (v == 10) ? 7'h7F : pat_tab[v];
      s[0]   = 1'($urandom_range(0, 1));
    end
    return s;
  endfunction

  always @(posedge CLK) begin
    exp_t e;
    #1;
    if (UPDATE === 1'b1)   upd_seen++;
    if (SCAN_ERR === 1'b1) serr_seen++;
    if (DIGITS[3:0] === 4'h5) saw5 = 1'b1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      checks++;
      if (DIGITS !== e.digits || DP !== e.dp || DIG_ERR !== e.err ||
          UPDATE !== e.upd || SCAN_ERR !== e.serr) begin
        errors++;
        $display("FAIL cycle_cmp @%0t: got D=%h DP=%b E=%b U=%b S=%b expected D=%h DP=%b E=%b U=%b S=%b",
                 $time, DIGITS, DP, DIG_ERR, UPDATE, SCAN_ERR,
                 e.digits, e.dp, e.err, e.upd, e.serr);
      end
    end
  end

  localparam logic [7:0] S1  = 8'b10011111;
  localparam logic [7:0] S2  = 8'b00100101;
  localparam logic [7:0] S3  = 8'b00001101;
  localparam logic [7:0] S4  = 8'b10011001;
  localparam logic [7:0] S7  = 8'b00011111;
  localparam logic [7:0] S9  = 8'b00001001;
  localparam logic [7:0] S8  = 8'b00000001;
  localparam logic [7:0] S5D = 8'b01001000;
  localparam logic [7:0] S6  = 8'b01000001;
  localparam logic [7:0] SBAD = 8'b01010101;

  initial begin
    int u0;
    int s0;
    logic [7:0] sticky [4];
    int kind;
    int len;
    int k;
    logic [3:0] an;

    model_clear();
    apply_reset(3);
    idle(4);
    check_lit("reset_digits", 32'(DIGITS), 32'h0000FFFF);
    check_lit("reset_dp", 32'(DP), 32'h0);
    check_lit("reset_err", 32'(DIG_ERR), 32'h0);
    check_lit("reset_pulses", 32'(upd_seen + serr_seen), 32'h0);

    u0 = upd_seen;
    repeat (2) begin
      activate(0, S1, 4); activate(1, S2, 4); activate(2, S3, 4); activate(3, S9, 4);
    end
    idle(3);
    check_lit("scan_digits", 32'(DIGITS), 32'h00009321);
    check_lit("scan_updates", 32'(upd_seen - u0), 32'd4);
    check_lit("scan_dp", 32'(DP), 32'h0);
    u0 = upd_seen;
    activate(0, S1, 4); activate(1, S2, 4); activate(2, S3, 4); activate(3, S9, 4);
    idle(3);
    check_lit("third_pass_updates", 32'(upd_seen - u0), 32'd0);

    saw5 = 1'b0;
    activate(0, S5D, 4); idle(1);
    activate(0, S6, 4);  idle(1);
    activate(0, S6, 4);  idle(3);
    check_lit("dig0_value", 32'(DIGITS[3:0]), 32'h6);
    check_lit("dig0_dp", 32'(DP[0]), 32'h0);
    check_lit("dig0_never5", 32'(saw5), 32'h0);

    activate(2, SBAD, 4); idle(1);
    activate(2, SBAD, 4); idle(3);
    check_lit("dig2_value", 32'(DIGITS[11:8]), 32'hF);
    check_lit("dig2_err", 32'(DIG_ERR[2]), 32'h1);

    s0 = serr_seen;
    activate(1, S7, 4);
    repeat (3) step(4'b1100, 8'hFF);
    activate(1, S7, 4); idle(3);
    check_lit("scan_err_pulses", 32'(serr_seen - s0), 32'd1);
    check_lit("dig1_after_multi", 32'(DIGITS[7:4]), 32'h7);

    u0 = upd_seen;
    repeat (4) begin
      step(4'b0111, S8);
      step(4'hF, 8'hFF);
    end
    idle(3);
    check_lit("short_act_digit", 32'(DIGITS[15:12]), 32'h9);
    check_lit("short_act_updates", 32'(upd_seen - u0), 32'd0);

    activate(1, S4, 4);
    step(4'b1101, S4);
    apply_reset(2);
    idle(2);
    check_lit("midreset_digits", 32'(DIGITS), 32'h0000FFFF);
    check_lit("midreset_err", 32'(DIG_ERR), 32'h0);
    activate(1, S4, 4); idle(2);
    check_lit("post_reset_one", 32'(DIGITS[7:4]), 32'hF);
    activate(1, S4, 4); idle(2);
    check_lit("post_reset_two", 32'(DIGITS[7:4]), 32'h4);

    for (int i = 0; i < 4; i++) sticky[i] = rand_seg();
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 9);
      len  = $urandom_range(1, 5);
      if (kind == 0) begin
        idle(len);
      end else if (kind == 1) begin
        an = 4'($urandom_range(0, 15));
        if ($countones(~an) < 2) an = 4'b0101;
        repeat (len) step(an, rand_seg());
      end else begin
        k = $urandom_range(0, 3);
        if ($urandom_range(0, 2) == 0) sticky[k] = rand_seg();
        activate(k, sticky[k], len);
      end
    end
    idle(4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
